// File: rtl/cache_request_issuer.sv
// Queues read/write commands and replays them one at a time on the level-sensitive cache interface.
// Latency: repeat read 1 cycle after pop, cache hit 3, repeat write 5, miss adds the fill time.
// Backpressure: cmd_ready drops when the FIFO is full; a response is held until rsp_ready.

module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             pushValid,
    output logic             pushReady,
    input  logic [WIDTH-1:0] pushData,
    output logic             popValid,
    input  logic             popReady,
    output logic [WIDTH-1:0] popData
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             doPush;
    logic             doPop;

    assign pushReady = (count != (AW+1)'(DEPTH));
    assign popValid  = (count != '0);
    assign doPush    = pushValid && pushReady;
    assign doPop     = popReady && popValid;
    assign popData   = store[rdPtr];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (!doPush && doPop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) store[wrPtr] <= pushData;
    end
endmodule

module cache_request_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 31
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wren,
    input  logic [4:0] cmd_address,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_wren,
    output logic [4:0] rsp_address,
    output logic       rsp_timeout,
    output logic [4:0] mem_address,
    output logic [7:0] mem_data,
    output logic       mem_wren,
    input  logic [7:0] mem_q,
    input  logic       mem_valid,
    output logic       busy
);
    typedef struct packed {
        logic       wren;
        logic [4:0] address;
        logic [7:0] data;
    } command_t;

    typedef enum logic [2:0] {IDLE, PRIME_L, PRIME_W, LAUNCH, WAIT, RESP} state_t;

    state_t     state, nextState;
    command_t   pushCmd, head, cur, curNext;
    logic       headValid, pop;
    logic [4:0] memAddressNext;
    logic [7:0] memDataNext;
    logic       memWrenNext;
    logic       rspValidNext, rspWrenNext, rspTimeoutNext;
    logic [7:0] rspDataNext;
    logic [4:0] rspAddressNext;
    logic [4:0] lastAddress, lastAddressNext;
    logic       lastWren, lastWrenNext;
    logic       lastOk, lastOkNext;
    logic [7:0] timer, timerNext;

    assign pushCmd = {cmd_wren, cmd_address, cmd_data};

    fifo #(
        .WIDTH($bits(command_t)),
        .DEPTH(FIFO_DEPTH)
    ) cmdFifo (
        .clock    (clock),
        .resetn   (resetn),
        .pushValid(cmd_valid),
        .pushReady(cmd_ready),
        .pushData (pushCmd),
        .popValid (headValid),
        .popReady (pop),
        .popData  (head)
    );

    assign busy = (state != IDLE) || headValid;

    always_comb begin
        nextState       = state;
        pop             = 1'b0;
        curNext         = cur;
        memAddressNext  = mem_address;
        memDataNext     = mem_data;
        memWrenNext     = mem_wren;
        rspValidNext    = rsp_valid;
        rspDataNext     = rsp_data;
        rspWrenNext     = rsp_wren;
        rspAddressNext  = rsp_address;
        rspTimeoutNext  = rsp_timeout;
        lastAddressNext = lastAddress;
        lastWrenNext    = lastWren;
        lastOkNext      = lastOk;
        timerNext       = timer;
        case (state)
            IDLE: begin
                if (headValid && !rsp_valid) begin
                    pop     = 1'b1;
                    curNext = head;
                    // The cache only starts a new access when address or wren change.
                    if (lastOk && !head.wren && !lastWren && head.address == lastAddress) begin
                        rspDataNext    = mem_q;
                        rspTimeoutNext = 1'b0;
                        rspWrenNext    = 1'b0;
                        rspAddressNext = head.address;
                        rspValidNext   = 1'b1;
                        nextState      = RESP;
                    end else if (lastOk && head.wren && lastWren && head.address == lastAddress) begin
                        memAddressNext = head.address;
                        memWrenNext    = 1'b0;
                        nextState      = PRIME_L;
                    end else begin
                        memAddressNext = head.address;
                        memDataNext    = head.data;
                        memWrenNext    = head.wren;
                        nextState      = LAUNCH;
                    end
                end
            end
            PRIME_L: begin
                timerNext = '0;
                nextState = PRIME_W;
            end
            PRIME_W: begin
                if (mem_valid) begin
                    memWrenNext = 1'b1;
                    memDataNext = cur.data;
                    nextState   = LAUNCH;
                end else if (timer == 8'(TIMEOUT - 1)) begin
                    rspDataNext    = '0;
                    rspTimeoutNext = 1'b1;
                    rspWrenNext    = cur.wren;
                    rspAddressNext = cur.address;
                    rspValidNext   = 1'b1;
                    lastOkNext     = 1'b0;
                    nextState      = RESP;
                end else begin
                    timerNext = timer + 8'd1;
                end
            end
            LAUNCH: begin
                timerNext = '0;
                nextState = WAIT;
            end
            WAIT: begin
                if (mem_valid) begin
                    rspDataNext     = mem_q;
                    rspTimeoutNext  = 1'b0;
                    rspWrenNext     = cur.wren;
                    rspAddressNext  = cur.address;
                    rspValidNext    = 1'b1;
                    lastAddressNext = cur.address;
                    lastWrenNext    = cur.wren;
                    lastOkNext      = 1'b1;
                    nextState       = RESP;
                end else if (timer == 8'(TIMEOUT - 1)) begin
                    rspDataNext    = '0;
                    rspTimeoutNext = 1'b1;
                    rspWrenNext    = cur.wren;
                    rspAddressNext = cur.address;
                    rspValidNext   = 1'b1;
                    lastOkNext     = 1'b0;
                    nextState      = RESP;
                end else begin
                    timerNext = timer + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rspValidNext = 1'b0;
                    nextState    = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cur         <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_wren    <= 1'b0;
            rsp_address <= '0;
            rsp_timeout <= 1'b0;
            lastAddress <= '0;
            lastWren    <= 1'b0;
            lastOk      <= 1'b0;
            timer       <= '0;
        end else begin
            state       <= nextState;
            cur         <= curNext;
            mem_address <= memAddressNext;
            mem_data    <= memDataNext;
            mem_wren    <= memWrenNext;
            rsp_valid   <= rspValidNext;
            rsp_data    <= rspDataNext;
            rsp_wren    <= rspWrenNext;
            rsp_address <= rspAddressNext;
            rsp_timeout <= rspTimeoutNext;
            lastAddress <= lastAddressNext;
            lastWren    <= lastWrenNext;
            lastOk      <= lastOkNext;
            timer       <= timerNext;
        end
    end
endmodule

// File: tb/tb_cache_request_issuer.sv
// Bench for cache_request_issuer: a behavioural cache stub plus an in-order memory reference model.

module tb_cache_request_issuer;
    localparam int TIMEOUT = 31;

    typedef struct packed {
        logic       wren;
        logic [4:0] address;
        logic [7:0] data;
        logic       timeout;
    } rsp_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic       cmd_valid, cmd_ready, cmd_wren;
    logic [4:0] cmd_address;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready, rsp_wren, rsp_timeout;
    logic [7:0] rsp_data;
    logic [4:0] rsp_address;
    logic [4:0] mem_address;
    logic [7:0] mem_data;
    logic       mem_wren;
    logic [7:0] mem_q;
    logic       mem_valid;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int pushCycle = 0;
    int rspCycle = 0;
    logic stubStuck = 1'b0;
    int stubMaxLat = 0;
    logic [7:0] refMem [32];

    cache_request_issuer #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wren(cmd_wren),
        .cmd_address(cmd_address), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_wren(rsp_wren), .rsp_address(rsp_address), .rsp_timeout(rsp_timeout),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .mem_valid(mem_valid), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    function automatic logic [7:0] initVal(input int i);
        if (i == 1)  return 8'h03;
        if (i == 16) return 8'h01;
        return 8'((i * 5 + 7) & 255);
    endfunction

    // Memory seen in command order: writes land, reads return the latest value.
    function automatic logic [7:0] refExpect(input logic w, input logic [4:0] a, input logic [7:0] d);
        if (w) begin
            refMem[a] = d;
            return d;
        end
        return refMem[a];
    endfunction

    // Cache stub: a change of address or wren is a new access; valid returns after a random latency.
    initial begin : cacheStub
        logic [7:0] smem [32];
        logic [4:0] prevA;
        logic       prevW;
        logic       pend;
        int         rem;
        int         lat;
        for (int i = 0; i < 32; i++) smem[i] = initVal(i);
        prevA = '0; prevW = 1'b0; pend = 1'b0; rem = 0;
        mem_valid = 1'b1;
        mem_q = initVal(0);
        forever begin
            @(posedge clock);
            if (mem_address !== prevA || mem_wren !== prevW) begin
                prevA = mem_address;
                prevW = mem_wren;
                lat = (stubMaxLat == 0) ? 0 : int'($urandom_range(0, stubMaxLat));
                if (!stubStuck && lat == 0) begin
                    if (mem_wren) begin smem[mem_address] = mem_data; mem_q <= mem_data; end
                    else mem_q <= smem[mem_address];
                    mem_valid <= 1'b1;
                    pend = 1'b0;
                end else begin
                    mem_valid <= 1'b0;
                    pend = 1'b1;
                    rem = lat;
                end
            end else if (pend && !stubStuck) begin
                if (rem <= 1) begin
                    if (mem_wren) begin smem[mem_address] = mem_data; mem_q <= mem_data; end
                    else mem_q <= smem[mem_address];
                    mem_valid <= 1'b1;
                    pend = 1'b0;
                end else begin
                    rem = rem - 1;
                end
            end
        end
    end

    task automatic pushCmd(input logic w, input logic [4:0] a, input logic [7:0] d);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clock); n++; end
        if (cmd_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL push_wait: cmd_ready=%b, required 1 within 200 cycles", cmd_ready);
            return;
        end
        cmd_valid = 1'b1; cmd_wren = w; cmd_address = a; cmd_data = d;
        @(negedge clock);
        pushCycle = cycle;
        cmd_valid = 1'b0;
    endtask

    task automatic getRsp(output rsp_t r);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 300) begin @(negedge clock); n++; end
        if (rsp_valid !== 1'b1) begin
            tests++; fails++;
            $display("FAIL rsp_wait: rsp_valid=%b, required 1 within 300 cycles", rsp_valid);
            r = 'x; rspCycle = -1000;
            return;
        end
        rspCycle = cycle;
        r = {rsp_wren, rsp_address, rsp_data, rsp_timeout};
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        tests++; if ({rsp_valid, rsp_data, rsp_wren, rsp_address, rsp_timeout} !== 16'h0) begin
            fails++; $display("FAIL reset_rsp: rsp_*=%h, required 0", {rsp_valid, rsp_data, rsp_wren, rsp_address, rsp_timeout}); end
        tests++; if ({mem_address, mem_data, mem_wren} !== 14'h0) begin
            fails++; $display("FAIL reset_mem: mem_*=%h, required 0", {mem_address, mem_data, mem_wren}); end
        tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_flags: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy); end
        resetn = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_hit_read;
        rsp_t r;
        stubMaxLat = 0;
        pushCmd(1'b0, 5'h01, 8'h00);
        getRsp(r);
        tests++; if (r !== {1'b0, 5'h01, refExpect(1'b0, 5'h01, 8'h00), 1'b0} || r.data !== 8'h03) begin
            fails++; $display("FAIL hit_read01: rsp=%h, required %h", r, {1'b0, 5'h01, 8'h03, 1'b0}); end
        tests++; if (rspCycle - pushCycle !== 3) begin
            fails++; $display("FAIL hit_lat01: latency=%0d, required 3", rspCycle - pushCycle); end
        pushCmd(1'b0, 5'h10, 8'h00);
        getRsp(r);
        tests++; if (r !== {1'b0, 5'h10, refExpect(1'b0, 5'h10, 8'h00), 1'b0} || r.data !== 8'h01) begin
            fails++; $display("FAIL hit_read10: rsp=%h, required %h", r, {1'b0, 5'h10, 8'h01, 1'b0}); end
        tests++; if (rspCycle - pushCycle !== 3) begin
            fails++; $display("FAIL hit_lat10: latency=%0d, required 3", rspCycle - pushCycle); end
    endtask

    task automatic test_write_read;
        rsp_t r;
        pushCmd(1'b1, 5'h00, 8'hAA);
        getRsp(r);
        tests++; if (r !== {1'b1, 5'h00, refExpect(1'b1, 5'h00, 8'hAA), 1'b0}) begin
            fails++; $display("FAIL write00: rsp=%h, required %h", r, {1'b1, 5'h00, 8'hAA, 1'b0}); end
        tests++; if (mem_wren !== 1'b1) begin
            fails++; $display("FAIL write_wren: mem_wren=%b, required 1", mem_wren); end
        pushCmd(1'b0, 5'h00, 8'h00);
        getRsp(r);
        tests++; if (r !== {1'b0, 5'h00, refExpect(1'b0, 5'h00, 8'h00), 1'b0} || r.data !== 8'hAA) begin
            fails++; $display("FAIL readback00: rsp=%h, required %h", r, {1'b0, 5'h00, 8'hAA, 1'b0}); end
        tests++; if (mem_wren !== 1'b0) begin
            fails++; $display("FAIL read_wren: mem_wren=%b, required 0", mem_wren); end
    endtask

    task automatic test_repeat_write;
        rsp_t r;
        logic sawPrime = 1'b0;
        logic sawWrite = 1'b0;
        int n = 0;
        pushCmd(1'b1, 5'h10, 8'h11);
        getRsp(r);
        tests++; if (r !== {1'b1, 5'h10, refExpect(1'b1, 5'h10, 8'h11), 1'b0}) begin
            fails++; $display("FAIL write10_first: rsp=%h, required %h", r, {1'b1, 5'h10, 8'h11, 1'b0}); end
        pushCmd(1'b1, 5'h10, 8'h22);
        while (rsp_valid !== 1'b1 && n < 300) begin
            if (mem_wren === 1'b0 && mem_address === 5'h10) sawPrime = 1'b1;
            if (sawPrime && mem_wren === 1'b1 && mem_data === 8'h22) sawWrite = 1'b1;
            @(negedge clock); n++;
        end
        getRsp(r);
        tests++; if (r !== {1'b1, 5'h10, refExpect(1'b1, 5'h10, 8'h22), 1'b0}) begin
            fails++; $display("FAIL write10_second: rsp=%h, required %h", r, {1'b1, 5'h10, 8'h22, 1'b0}); end
        tests++; if ({sawPrime, sawWrite} !== 2'b11) begin
            fails++; $display("FAIL prime_seq: prime=%b write_after=%b, required 1 1", sawPrime, sawWrite); end
        tests++; if (rspCycle - pushCycle !== 5) begin
            fails++; $display("FAIL prime_lat: latency=%0d, required 5", rspCycle - pushCycle); end
        pushCmd(1'b0, 5'h10, 8'h00);
        getRsp(r);
        tests++; if (r !== {1'b0, 5'h10, refExpect(1'b0, 5'h10, 8'h00), 1'b0} || r.data !== 8'h22) begin
            fails++; $display("FAIL read10_after: rsp=%h, required %h", r, {1'b0, 5'h10, 8'h22, 1'b0}); end
    endtask

    task automatic test_repeat_read;
        rsp_t r;
        logic [4:0] a0;
        logic w0;
        logic changed = 1'b0;
        int n = 0;
        pushCmd(1'b0, 5'h01, 8'h00);
        getRsp(r);
        tests++; if (r !== {1'b0, 5'h01, refExpect(1'b0, 5'h01, 8'h00), 1'b0}) begin
            fails++; $display("FAIL rr_first: rsp=%h, required %h", r, {1'b0, 5'h01, refMem[1], 1'b0}); end
        a0 = mem_address; w0 = mem_wren;
        pushCmd(1'b0, 5'h01, 8'h00);
        while (rsp_valid !== 1'b1 && n < 300) begin
            if (mem_address !== a0 || mem_wren !== w0) changed = 1'b1;
            @(negedge clock); n++;
        end
        getRsp(r);
        tests++; if (r !== {1'b0, 5'h01, refExpect(1'b0, 5'h01, 8'h00), 1'b0} || r.data !== 8'h03) begin
            fails++; $display("FAIL rr_second: rsp=%h, required %h", r, {1'b0, 5'h01, 8'h03, 1'b0}); end
        tests++; if (rspCycle - pushCycle !== 1 || changed !== 1'b0) begin
            fails++; $display("FAIL rr_shortcut: latency=%0d mem_changed=%b, required 1 0", rspCycle - pushCycle, changed); end
    endtask

    task automatic test_backpressure;
        rsp_t exp [$];
        rsp_t r;
        logic w;
        logic [4:0] a;
        logic [7:0] d;
        stubMaxLat = 3;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 5'($urandom_range(0, 31));
            d = 8'($urandom);
            pushCmd(w, a, d);
            exp.push_back({w, a, refExpect(w, a, d), 1'b0});
        end
        tests++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL bp_full: cmd_ready=%b busy=%b, required 0 1", cmd_ready, busy); end
        for (int i = 0; i < 5; i++) begin
            getRsp(r);
            tests++; if (r !== exp[i]) begin
                fails++; $display("FAIL bp_rsp%0d: rsp=%h, required %h", i, r, exp[i]); end
        end
    endtask

    task automatic test_random;
        localparam int N = 60;
        logic [13:0] expQ [$];
        int got = 0;
        stubMaxLat = 4;
        fork
            begin : pusher
                logic w;
                logic [4:0] a;
                logic [7:0] d;
                int sel;
                for (int i = 0; i < N; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clock);
                    sel = int'($urandom_range(0, 3));
                    a = (sel == 0) ? 5'h01 : (sel == 1) ? 5'h02 : (sel == 2) ? 5'h10 : 5'($urandom_range(0, 31));
                    w = ($urandom_range(0, 2) == 0);
                    d = 8'($urandom);
                    pushCmd(w, a, d);
                    expQ.push_back({w, a, refExpect(w, a, d)});
                end
            end
            begin : collector
                int guard = 0;
                logic [13:0] e;
                while (got < N && guard < 3000) begin
                    @(negedge clock); guard++;
                    rsp_ready = 1'b0;
                    if (rsp_valid === 1'b1 && $urandom_range(0, 2) != 0) begin
                        tests++;
                        if (expQ.size() == 0) begin
                            fails++; $display("FAIL rand_extra: response %0d with empty model queue", got);
                        end else begin
                            e = expQ.pop_front();
                            if ({rsp_wren, rsp_address, rsp_data, rsp_timeout} !== {e, 1'b0}) begin
                                fails++;
                                $display("FAIL rand_rsp%0d: rsp=%h, required %h", got, {rsp_wren, rsp_address, rsp_data, rsp_timeout}, {e, 1'b0});
                            end
                        end
                        rsp_ready = 1'b1;
                        got++;
                    end
                end
                @(negedge clock);
                rsp_ready = 1'b0;
            end
        join
        tests++; if (got != N) begin
            fails++; $display("FAIL rand_count: responses=%0d, required %0d", got, N); end
    endtask

    task automatic test_timeout;
        rsp_t r;
        stubMaxLat = 0;
        pushCmd(1'b0, 5'h02, 8'h00);
        getRsp(r);
        tests++; if (r !== {1'b0, 5'h02, refExpect(1'b0, 5'h02, 8'h00), 1'b0}) begin
            fails++; $display("FAIL to_pre: rsp=%h, required %h", r, {1'b0, 5'h02, refMem[2], 1'b0}); end
        stubStuck = 1'b1;
        pushCmd(1'b0, 5'h07, 8'h00);
        getRsp(r);
        tests++; if (r !== {1'b0, 5'h07, 8'h00, 1'b1}) begin
            fails++; $display("FAIL to_rsp: rsp=%h, required %h", r, {1'b0, 5'h07, 8'h00, 1'b1}); end
        tests++; if (rspCycle - pushCycle !== TIMEOUT + 2) begin
            fails++; $display("FAIL to_lat: latency=%0d, required %0d", rspCycle - pushCycle, TIMEOUT + 2); end
        stubStuck = 1'b0;
        repeat (5) @(negedge clock);
        pushCmd(1'b0, 5'h07, 8'h00);
        getRsp(r);
        tests++; if (r !== {1'b0, 5'h07, refExpect(1'b0, 5'h07, 8'h00), 1'b0}) begin
            fails++; $display("FAIL to_reread: rsp=%h, required %h", r, {1'b0, 5'h07, refMem[7], 1'b0}); end
        tests++; if (rspCycle - pushCycle !== 3) begin
            fails++; $display("FAIL to_relaunch_lat: latency=%0d, required 3", rspCycle - pushCycle); end
    endtask

    task automatic test_reset_mid_access;
        rsp_t r;
        logic sawRsp = 1'b0;
        stubStuck = 1'b1;
        pushCmd(1'b0, 5'h09, 8'h00);
        repeat (6) @(negedge clock);
        resetn = 1'b0;
        #1;
        tests++; if ({rsp_valid, rsp_data, rsp_wren, rsp_address, rsp_timeout, mem_address, mem_data, mem_wren} !== 30'h0) begin
            fails++; $display("FAIL midreset_outs: outs=%h, required 0",
                {rsp_valid, rsp_data, rsp_wren, rsp_address, rsp_timeout, mem_address, mem_data, mem_wren}); end
        tests++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL midreset_flags: busy=%b cmd_ready=%b, required 0 1", busy, cmd_ready); end
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        stubStuck = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0) sawRsp = 1'b1;
        end
        tests++; if (sawRsp !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL midreset_norsp: rsp_seen=%b busy=%b, required 0 0", sawRsp, busy); end
        pushCmd(1'b0, 5'h01, 8'h00);
        getRsp(r);
        tests++; if (r !== {1'b0, 5'h01, refExpect(1'b0, 5'h01, 8'h00), 1'b0} || rspCycle - pushCycle !== 3) begin
            fails++; $display("FAIL midreset_after: rsp=%h lat=%0d, required %h 3", r, rspCycle - pushCycle, {1'b0, 5'h01, refMem[1], 1'b0}); end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) refMem[i] = initVal(i);
        resetn = 1'b0;
        cmd_valid = 1'b0; cmd_wren = 1'b0; cmd_address = '0; cmd_data = '0;
        rsp_ready = 1'b0;
        test_reset;
        test_hit_read;
        test_write_read;
        test_repeat_write;
        test_repeat_read;
        test_backpressure;
        test_random;
        test_timeout;
        test_reset_mid_access;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_request_issuer.md
Name: cache_request_issuer

Overview:
- Upstream command stage for the 4-line write-back cache (`memory`: address[4:0], data[7:0], wren, q[7:0], valid).
- Buffers read/write commands from the datapath/controller in a small FIFO and presents them one at a time on the cache's level-sensitive interface.
- Holds each request stable until the cache's valid asserts, then returns the result on a valid/ready response port.
- Handles the cache's "new request = address or wren changed" rule, and bounds a stuck access with a timeout.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥2.
- TIMEOUT, 31: number of WAIT cycles without mem_valid before the request is abandoned; 1..255.

Ports:
- clock  in  1  rising-edge clock, shared with the cache.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_wren  in  1  1 = write, 0 = read.
- cmd_address  in  5  target address.
- cmd_data  in  8  write data; ignored for reads.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  8  read data, or the data written for writes; 0 on timeout.
- rsp_wren  out  1  echo of the command's wren.
- rsp_address  out  5  echo of the command's address.
- rsp_timeout  out  1  request abandoned.
- mem_address  out  5  to cache address.
- mem_data  out  8  to cache data.
- mem_wren  out  1  to cache wren.
- mem_q  in  8  from cache q.
- mem_valid  in  1  from cache valid.
- busy  out  1  state ≠ IDLE or FIFO not empty.

Behaviour:
- Reset (async, resetn=0):
  - FIFO empty; state IDLE.
  - rsp_valid=0; rsp_data=0; rsp_wren=0; rsp_address=0; rsp_timeout=0.
  - mem_address=0; mem_data=0; mem_wren=0.
  - last_ok=0; timeout counter cleared.
  - Reset mid-access abandons the access and produces no response; the cache is not reset and finishes on its own.
- FIFO:
  - cmd_ready = !full; a push happens when cmd_valid && cmd_ready at the edge.
  - A push and a pop in the same cycle are allowed whenever the FIFO is not full.
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
  - Ordering is strict FIFO; responses are returned in command order.
- Tracking registers: last_address, last_wren, last_ok.
  - Set when a request completes via mem_valid.
  - last_ok is cleared on reset and on timeout.
- State machine:
  - IDLE: when the FIFO is non-empty and rsp_valid=0, pop the head.
    - If last_ok && the head is a read && last_wren=0 && head address == last_address: go to RESP directly, rsp_data=mem_q, no cache access (the cache would not see a new request).
    - Else if last_ok && the head is a write && last_wren=1 && head address == last_address: drive mem_wren=0 with the same address, go to PRIME_L.
    - Otherwise drive mem_address, mem_data and mem_wren from the head and go to LAUNCH.
  - PRIME_L, 1 cycle: go to PRIME_W. mem_valid is ignored because it may be stale.
  - PRIME_W: when mem_valid=1, drive the head's write (mem_wren=1, mem_data) and go to LAUNCH.
  - LAUNCH, 1 cycle: mem_* held; mem_valid ignored, since the cache samples the new request at this edge. Go to WAIT.
  - WAIT: mem_* held stable, because the cache's hit-write uses live data.
    - When mem_valid=1: capture mem_q into rsp_data, set rsp_timeout=0, update last_*, set last_ok=1, go to RESP.
    - After TIMEOUT cycles with mem_valid=0: rsp_data=0, rsp_timeout=1, last_ok=0, go to RESP.
    - The counter covers PRIME_W and WAIT separately.
  - RESP: rsp_valid=1 with all rsp_* stable. When rsp_ready=1, clear rsp_valid and go to IDLE.
- mem_* keep their last driven value in IDLE and RESP (no spurious cache request).
- Latency, command to response:
  - Repeat read: 1 cycle after the pop.
  - Cache hit: pop + LAUNCH + 1 = 3 cycles.
  - Miss: adds the cache's fill/write-back time.
  - Repeat write: adds a primed read hit.
- rsp_ready held high: the next pop occurs the cycle after acceptance (1 idle cycle per request).

Test Plan:
- Reset with the cache's initial contents; read 0x01 → rsp_data=0x03, rsp_timeout=0, hit latency 3 cycles; then read 0x10 → 0x01.
- Write 0x00←0xAA, then read 0x00 → write response echoes 0xAA; read returns 0xAA with mem_wren toggling 1→0.
- Write 0x10←0x11 then write 0x10←0x22 → a PRIME read appears on mem_* (wren 0) before the second write; a subsequent read 0x10 returns 0x22.
- Read 0x01 twice → the second response arrives without any change on mem_address/mem_wren, data 0x03.
- Push 5 commands with rsp_ready=0 → cmd_ready drops after 4 are buffered; all 5 responses come out in order once rsp_ready=1.
- Hold mem_valid=0 (cache stub) → after 31 WAIT cycles rsp_timeout=1 and rsp_data=0; a following read of the same address re-launches (no repeat shortcut). Assert resetn=0 in WAIT → outputs return to reset values immediately and no response is produced.
